// File: rtl/fb_pkg.sv
// Default raster timing, pixel width and shared types for the framebuffer scan arbiter.
package fb_pkg;

    localparam int unsigned DefWidth  = 128;
    localparam int unsigned DefHeight = 128;
    localparam int unsigned DefMaxX   = 800;
    localparam int unsigned DefMaxY   = 525;
    localparam int unsigned DefHfp    = 16;
    localparam int unsigned DefHsw    = 96;
    localparam int unsigned DefVfp    = 10;
    localparam int unsigned DefVsw    = 2;
    localparam int unsigned RgbW      = 24;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } scan_ctl_t;

    function automatic int unsigned fb_addr_w(input int unsigned w, input int unsigned h);
        return unsigned'($clog2(w * h));
    endfunction

endpackage

// File: rtl/fb_timing.sv
// Raster counters with active/sync decode and the frame-wrap and bank-swap strobes.
module fb_timing
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned HEIGHT = DefHeight,
    parameter int unsigned MAX_X  = DefMaxX,
    parameter int unsigned MAX_Y  = DefMaxY,
    parameter int unsigned HFP    = DefHfp,
    parameter int unsigned HSW    = DefHsw,
    parameter int unsigned VFP    = DefVfp,
    parameter int unsigned VSW    = DefVsw
) (
    input  logic      i_clk,
    input  logic      i_rst,
    output scan_ctl_t o_ctl,
    output logic      o_frame_last,
    output logic      o_swap_pt
);

    localparam int unsigned XW = $clog2(MAX_X + 1);
    localparam int unsigned YW = $clog2(MAX_Y + 1);

    localparam logic [XW-1:0] XLast   = XW'(MAX_X - 1);
    localparam logic [YW-1:0] YLast   = YW'(MAX_Y - 1);
    localparam logic [XW-1:0] XAct    = XW'(WIDTH);
    localparam logic [YW-1:0] YAct    = YW'(HEIGHT);
    localparam logic [YW-1:0] YSwap   = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] HsStart = XW'(WIDTH + HFP);
    localparam logic [XW-1:0] HsEnd   = XW'(WIDTH + HFP + HSW);
    localparam logic [YW-1:0] VsStart = YW'(HEIGHT + VFP);
    localparam logic [YW-1:0] VsEnd   = YW'(HEIGHT + VFP + VSW);

    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;
    logic          w_x_last;
    logic          w_y_last;

    assign w_x_last = (r_cx == XLast);
    assign w_y_last = (r_cy == YLast);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_x_last) begin
            r_cx <= '0;
            r_cy <= w_y_last ? '0 : r_cy + 1'b1;
        end else begin
            r_cx <= r_cx + 1'b1;
        end
    end

    always_comb begin
        o_ctl     = '0;
        o_ctl.act = (r_cx < XAct) && (r_cy < YAct);
        o_ctl.hs  = (r_cx >= HsStart) && (r_cx < HsEnd);
        o_ctl.vs  = (r_cy >= VsStart) && (r_cy < VsEnd);
    end

    assign o_frame_last = w_x_last && w_y_last;
    assign o_swap_pt    = w_x_last && (r_cy == YSwap);

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port double-banked framebuffer scheduler: display prefetch during active video,
// plotter writes into the back bank during blanking, bank swap at the top of vblank.
module fb_scan_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned HEIGHT = DefHeight,
    parameter int unsigned MAX_X  = DefMaxX,
    parameter int unsigned MAX_Y  = DefMaxY,
    parameter int unsigned HFP    = DefHfp,
    parameter int unsigned HSW    = DefHsw,
    parameter int unsigned VFP    = DefVfp,
    parameter int unsigned VSW    = DefVsw,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = fb_addr_w(WIDTH, HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RgbW-1:0]   wr_data,
    output logic              wr_gnt,
    output logic              wr_drop,
    input  logic              frame_done,
    output logic              swap_ack,
    output logic              front_bank,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [RgbW-1:0]   mem_wdata,
    input  logic [RgbW-1:0]   mem_rdata,
    output logic              hSync_o,
    output logic              vSync_o,
    output logic              drawArea_o,
    output logic [RgbW-1:0]   pixel_o
);

    localparam int unsigned     D      = RD_LAT + 2;
    localparam logic [ADDR_W:0] Pixels = (ADDR_W + 1)'(WIDTH * HEIGHT);

    scan_ctl_t             w_ctl;
    logic                  w_frame_last;
    logic                  w_swap_pt;
    logic                  w_accept;
    logic                  w_oob;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic                  r_pending;
    scan_ctl_t [D-2:0]     r_pipe;

    fb_timing #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .MAX_X  (MAX_X),
        .MAX_Y  (MAX_Y),
        .HFP    (HFP),
        .HSW    (HSW),
        .VFP    (VFP),
        .VSW    (VSW)
    ) u_timing (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_ctl        (w_ctl),
        .o_frame_last (w_frame_last),
        .o_swap_pt    (w_swap_pt)
    );

    assign wr_gnt   = wr_req && !w_ctl.act && !rst;
    assign w_accept = wr_req && wr_gnt;
    assign w_oob    = ({1'b0, wr_addr} >= Pixels);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wr_drop    <= 1'b0;
            r_rd_addr  <= '0;
            front_bank <= 1'b0;
            r_pending  <= 1'b0;
            swap_ack   <= 1'b0;
            r_pipe     <= '0;
            hSync_o    <= 1'b0;
            vSync_o    <= 1'b0;
            drawArea_o <= 1'b0;
            pixel_o    <= '0;
        end else begin
            // Address and write data hold on idle and dropped cycles.
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            wr_drop <= w_accept && w_oob;
            if (w_ctl.act) begin
                mem_en   <= 1'b1;
                mem_addr <= {front_bank, r_rd_addr};
            end else if (w_accept && !w_oob) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {~front_bank, wr_addr};
                mem_wdata <= wr_data;
            end

            if (w_frame_last) begin
                r_rd_addr <= '0;
            end else if (w_ctl.act) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end

            // A frame_done on the swap edge is absorbed by the swap itself.
            swap_ack <= 1'b0;
            if (w_swap_pt && (r_pending || frame_done)) begin
                front_bank <= ~front_bank;
                r_pending  <= 1'b0;
                swap_ack   <= 1'b1;
            end else if (frame_done) begin
                r_pending <= 1'b1;
            end

            r_pipe     <= {r_pipe[D-3:0], w_ctl};
            hSync_o    <= r_pipe[D-2].hs;
            vSync_o    <= r_pipe[D-2].vs;
            drawArea_o <= r_pipe[D-2].act;
            pixel_o    <= r_pipe[D-2].act ? mem_rdata : '0;
        end
    end

endmodule
